// File: rtl/pulse_stretch_seq.sv
// rtl/pulse_stretch_seq.sv - stretches single-cycle requests into fixed-width pulses with a queued replay
module pulse_stretch_seq #(
    parameter int  SYSCLK_FREQ = 24000000,
    parameter real ON_TIME     = 0.150,
    parameter real GAP_TIME    = 0.100,
    parameter int  PEND_MAX    = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            trig,
    input  logic                            clr_drop,
    output logic                            Q,
    output logic                            busy,
    output logic [$clog2(PEND_MAX+1)-1:0]   pending,
    output logic                            dropped
);

    localparam int ON_CYCLES  = int'(real'(SYSCLK_FREQ) * ON_TIME);
    localparam int GAP_CYCLES = int'(real'(SYSCLK_FREQ) * GAP_TIME);
    localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int PW         = $clog2(PEND_MAX + 1);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          dropped_q, dropped_d;

    logic [PW-1:0] pending_post;
    logic          queue_trig;
    logic          dec;
    logic          drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        dropped_d    = dropped_q;
        pending_post = pending_q;
        queue_trig   = 1'b0;
        dec          = 1'b0;
        drop         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = ON;
                    timer_d = '0;
                end
            end
            ON: begin
                queue_trig = trig;
                if (timer_q == ON_LAST) begin
                    state_d = GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (pending_q != '0) begin
                        state_d    = ON;
                        dec        = 1'b1;
                        queue_trig = trig;
                    end else if (trig) begin
                        // Empty queue: the request starts the next pulse directly, skipping IDLE
                        state_d = ON;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d    = timer_q + CW'(1);
                    queue_trig = trig;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Saturation is judged after the replay decrement, so a full queue at GAP end accepts one more
        pending_post = pending_q - PW'(dec);
        drop         = queue_trig && (pending_post == PEND_FULL);
        pending_d    = (queue_trig && !drop) ? pending_post + PW'(1) : pending_post;

        if (drop) begin
            dropped_d = 1'b1;
        end else if (clr_drop) begin
            dropped_d = 1'b0;
        end
    end

    always_comb begin
        Q       = (state_q == ON);
        busy    = (state_q != IDLE);
        pending = pending_q;
        dropped = dropped_q;
    end

endmodule

// File: tb/tb_pulse_stretch_seq.sv
// tb/tb_pulse_stretch_seq.sv - randomized and directed bench against a time-based pulse schedule model
module tb_pulse_stretch_seq;

    localparam int ON_C     = 4;
    localparam int GAP_C    = 2;
    localparam int PERIOD   = ON_C + GAP_C;
    localparam int PEND_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       clr_drop = 1'b0;
    logic       Q;
    logic       busy;
    logic [1:0] pending;
    logic       dropped;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a pulse is described by the edge number it started on; the queue is a plain count
    int edge_n  = 0;
    bit m_act   = 0;
    int m_start = 0;
    int m_pend  = 0;
    bit m_drop  = 0;

    pulse_stretch_seq #(
        .SYSCLK_FREQ(1000),
        .ON_TIME    (0.004),
        .GAP_TIME   (0.002),
        .PEND_MAX   (PEND_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .clr_drop(clr_drop),
        .Q       (Q),
        .busy    (busy),
        .pending (pending),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic enqueue(input bit t, inout bit drop);
        if (t) begin
            if (m_pend == PEND_MAX) drop = 1'b1;
            else m_pend++;
        end
    endtask

    task automatic model_edge(input bit t, input bit c);
        bit drop = 1'b0;
        edge_n++;
        if (m_act && edge_n >= m_start + PERIOD) begin
            if (m_pend > 0) begin
                m_pend--;
                m_start = edge_n;
                enqueue(t, drop);
            end else if (t) begin
                m_start = edge_n;
            end else begin
                m_act = 1'b0;
            end
        end else if (m_act) begin
            enqueue(t, drop);
        end else if (t) begin
            m_act   = 1'b1;
            m_start = edge_n;
        end
        if (drop) m_drop = 1'b1;
        else if (c) m_drop = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("Q",       int'(Q),       int'(m_act && (edge_n - m_start) < ON_C));
        check_eq("busy",    int'(busy),    int'(m_act));
        check_eq("pending", int'(pending), m_pend);
        check_eq("dropped", int'(dropped), int'(m_drop));
    endtask

    task automatic cycle(input bit t, input bit c);
        trig     = t;
        clr_drop = c;
        @(posedge clk);
        model_edge(t, c);
        #1;
        check_outputs();
    endtask

    task automatic drive(input int n, input bit t, input bit c);
        for (int i = 0; i < n; i++) cycle(t, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_act  = 1'b0;
        m_pend = 0;
        m_drop = 1'b0;
        check_outputs();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        drive(20, 1'b0, 1'b0);

        drive(1, 1'b1, 1'b0);
        drive(12, 1'b0, 1'b0);

        drive(3, 1'b1, 1'b0);
        drive(24, 1'b0, 1'b0);

        drive(6, 1'b1, 1'b0);
        drive(4, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b1);
        drive(30, 1'b0, 1'b0);

        drive(3, 1'b1, 1'b0);
        drive(3, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0);
        drive(20, 1'b0, 1'b0);

        drive(1, 1'b1, 1'b0);
        drive(5, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0);
        drive(12, 1'b0, 1'b0);

        drive(3, 1'b1, 1'b0);
        do_reset();
        drive(2, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0);
        drive(10, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            int density;
            density = (i / 100) % 4;
            cycle(($urandom_range(0, 7) < density * 2 + 1), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        drive(40, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
